// File: rtl/issue_execute_fifo.sv
// -----------------------------------------------------------------------------
// issue_execute_fifo
//   In-order queue between the issue stage and one execute unit (ALU, BRU,
//   CSR, DIV, LSU or MUL). The issue stage pushes packed issue entries and
//   watches full. The execute unit pops the head entry. A commit-side flush
//   empties the queue in one cycle.
//
// Ports
//   clk            in   clock, all state updates on posedge
//   rst            in   asynchronous active-low reset
//   push           in   enqueue data_in this cycle
//   data_in        in   entry to enqueue (issue_execute_pack_t)
//   full           out  no free entry
//   flush          in   discard all entries (highest priority)
//   pop            in   consume head entry this cycle
//   data_out       out  head entry (first-word-fall-through)
//   data_out_valid out  queue non-empty
//   count          out  number of valid entries, 0..DEPTH
//   push_rejected  out  registered pulse: previous cycle pushed into a full
//                       queue without a flush
// -----------------------------------------------------------------------------

package issue_execute_fifo_pkg;

    typedef struct packed {
        logic [5:0]  rob_id;
        logic [3:0]  fu_op;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] imm;
        logic [31:0] pc;
    } issue_execute_pack_t;

    localparam int PACK_W = $bits(issue_execute_pack_t);

endpackage

// Simulation-only invariant checks for the queue pointers and flags.
module issue_execute_fifo_chk #(
    parameter int DEPTH     = 2,
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst,
    input logic               flush,
    input logic               full,
    input logic               data_out_valid,
    input logic [PTR_WIDTH:0] count,
    input logic [PTR_WIDTH:0] wptr,
    input logic [PTR_WIDTH:0] rptr
);

    localparam logic [PTR_WIDTH:0] CNT_MAX = DEPTH[PTR_WIDTH:0];

    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        count <= CNT_MAX);

    a_full_valid: assert property (@(posedge clk) disable iff (!rst)
        full |-> data_out_valid);

    // An empty queue must not advance its read pointer, so no entry is
    // consumed a second time.
    a_no_double_pop: assert property (@(posedge clk) disable iff (!rst)
        ((rptr == wptr) && !flush) |=> (rptr == $past(rptr)));

endmodule

module issue_execute_fifo
    import issue_execute_fifo_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [PACK_W-1:0] data_in,
    output logic              full,
    input  logic              flush,
    input  logic              pop,
    output logic [PACK_W-1:0] data_out,
    output logic              data_out_valid,
    output logic [PTR_WIDTH:0] count,
    output logic              push_rejected
);

    localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

    logic [PACK_W-1:0]  mem_r [DEPTH];
    logic [PTR_WIDTH:0] wptr_r;
    logic [PTR_WIDTH:0] rptr_r;
    logic               push_rejected_r;

    logic               empty_s;
    logic               full_s;
    logic               do_push_s;
    logic               do_pop_s;
    logic               rejected_s;

    // Flags come only from registered pointers; the extra wrap bit separates
    // full (wrap bits differ) from empty (pointers equal).
    always_comb begin
        empty_s    = (wptr_r == rptr_r);
        full_s     = (wptr_r[PTR_WIDTH] != rptr_r[PTR_WIDTH]) &&
                     (wptr_r[PTR_WIDTH-1:0] == rptr_r[PTR_WIDTH-1:0]);
        do_push_s  = push && !full_s && !flush;
        do_pop_s   = pop && !empty_s && !flush;
        rejected_s = push && full_s && !flush;
    end

    assign full           = full_s;
    assign data_out_valid = !empty_s;
    assign count          = wptr_r - rptr_r;
    assign data_out       = mem_r[rptr_r[PTR_WIDTH-1:0]];
    assign push_rejected  = push_rejected_r;

    // Pointer and reject-pulse state; flush snaps the read pointer to the
    // write pointer and discards any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_r          <= '0;
            rptr_r          <= '0;
            push_rejected_r <= 1'b0;
        end else if (flush) begin
            rptr_r          <= wptr_r;
            push_rejected_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            push_rejected_r <= rejected_s;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wptr_r[PTR_WIDTH-1:0]] <= data_in;
        end
    end

    issue_execute_fifo_chk #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_chk (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .full           (full_s),
        .data_out_valid (!empty_s),
        .count          (count),
        .wptr           (wptr_r),
        .rptr           (rptr_r)
    );

endmodule
